// File: rtl/control_unit_if.sv
// Bus between the control unit and its program memory / datapath.
// The master side is the control unit; the slave side is memory plus datapath.
interface control_unit_if #(
    parameter int PC_WIDTH  = 11,
    parameter int CNT_WIDTH = 16
);
    logic [PC_WIDTH-1:0]  Instr_Addr;
    logic [15:0]          Instr_Data;
    logic [10:0]          Operand;
    logic [1:0]           SelA;
    logic                 SelB;
    logic                 WrAcc;
    logic                 Op;
    logic                 WrRam;
    logic                 RdRam;
    logic                 Halted;
    logic                 Illegal;
    logic [CNT_WIDTH-1:0] Cycle_Count;

    modport master (
        output Instr_Addr,
        input  Instr_Data,
        output Operand,
        output SelA,
        output SelB,
        output WrAcc,
        output Op,
        output WrRam,
        output RdRam,
        output Halted,
        output Illegal,
        output Cycle_Count
    );

    modport slave (
        input  Instr_Addr,
        output Instr_Data,
        input  Operand,
        input  SelA,
        input  SelB,
        input  WrAcc,
        input  Op,
        input  WrRam,
        input  RdRam,
        input  Halted,
        input  Illegal,
        input  Cycle_Count
    );
endinterface

// File: rtl/control_unit.sv
// Three-cycle FETCH/DECODE/EXECUTE sequencer for a small accumulator machine.
// Datapath strobes are decoded only from the state and instruction registers.
module control_unit #(
    parameter int PC_WIDTH  = 11,
    parameter int CNT_WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    control_unit_if.master bus
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        HALT    = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       wr_acc;
        logic       op;
        logic       wr_ram;
        logic       rd_ram;
    } ctrl_t;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    state_t               state_q,   state_d;
    logic [PC_WIDTH-1:0]  pc_q,      pc_d;
    logic [15:0]          ir_q,      ir_d;
    logic                 illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
    ctrl_t                ctrl;
    logic [4:0]           opcode;

    assign opcode = ir_q[15:11];

    function automatic ctrl_t decode_op(input logic [4:0] opc);
        ctrl_t c;
        c = '0;
        case (opc)
            OP_STO:  c.wr_ram = 1'b1;
            OP_LD:   begin c.rd_ram = 1'b1; c.sel_a = 2'b00; c.wr_acc = 1'b1; end
            OP_LDI:  begin c.sel_a = 2'b01; c.wr_acc = 1'b1; end
            OP_ADD:  begin c.rd_ram = 1'b1; c.sel_a = 2'b10; c.wr_acc = 1'b1; end
            OP_ADDI: begin c.sel_a = 2'b10; c.sel_b = 1'b1; c.wr_acc = 1'b1; end
            OP_SUB:  begin c.rd_ram = 1'b1; c.sel_a = 2'b10; c.op = 1'b1; c.wr_acc = 1'b1; end
            OP_SUBI: begin c.sel_a = 2'b10; c.sel_b = 1'b1; c.op = 1'b1; c.wr_acc = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        ctrl      = '0;

        // The edge that enters HALT still counts; only HALT itself freezes it.
        if (state_q != HALT && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            FETCH: begin
                state_d = DECODE;
            end
            DECODE: begin
                ir_d    = bus.Instr_Data;
                state_d = EXECUTE;
            end
            EXECUTE: begin
                ctrl = decode_op(opcode);
                if (opcode == OP_HLT) begin
                    state_d = HALT;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = FETCH;
                end
                if (opcode[4:3] != 2'b00) begin
                    illegal_d = 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign bus.Instr_Addr  = pc_q;
    assign bus.Operand     = ir_q[10:0];
    assign bus.SelA        = ctrl.sel_a;
    assign bus.SelB        = ctrl.sel_b;
    assign bus.WrAcc       = ctrl.wr_acc;
    assign bus.Op          = ctrl.op;
    assign bus.WrRam       = ctrl.wr_ram;
    assign bus.RdRam       = ctrl.rd_ram;
    assign bus.Halted      = (state_q == HALT);
    assign bus.Illegal     = illegal_q;
    assign bus.Cycle_Count = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-opcode vector table plus multi-cycle
// sequences (program run, PC wrap, reset abort, counter saturation).
module tb_control_unit;

    logic clk;
    logic reset;

    control_unit_if #(.PC_WIDTH(11), .CNT_WIDTH(16)) bus0 ();
    control_unit_if #(.PC_WIDTH(11), .CNT_WIDTH(4))  bus1 ();

    control_unit #(.PC_WIDTH(11), .CNT_WIDTH(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.master)
    );

    control_unit #(.PC_WIDTH(11), .CNT_WIDTH(4)) u_dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
    );

    logic [15:0] mem0 [0:2047];

    always @(posedge clk) bus0.Instr_Data <= mem0[bus0.Instr_Addr];
    assign bus1.Instr_Data = 16'h4000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] strobes;
    assign strobes = {bus0.SelA, bus0.SelB, bus0.WrAcc, bus0.Op, bus0.WrRam, bus0.RdRam};

    int total_cnt;
    int pass_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    task automatic clear_mem(input logic [15:0] fill);
        for (int a = 0; a < 2048; a++) mem0[a] = fill;
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [6:0]  exp_ctrl;
        logic        exp_illegal;
        logic        exp_halt;
    } vec_t;

    vec_t vecs [10];

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        reset     = 1'b1;

        // {SelA, SelB, WrAcc, Op, WrRam, RdRam}
        vecs[0] = '{16'h0000, 7'b00_0_0_0_0_0, 1'b0, 1'b1};  // HLT
        vecs[1] = '{16'h0810, 7'b00_0_0_0_1_0, 1'b0, 1'b0};  // STO 0x010
        vecs[2] = '{16'h1123, 7'b00_0_1_0_0_1, 1'b0, 1'b0};  // LD 0x123
        vecs[3] = '{16'h1805, 7'b01_0_1_0_0_0, 1'b0, 1'b0};  // LDI 5
        vecs[4] = '{16'h2007, 7'b10_0_1_0_0_1, 1'b0, 1'b0};  // ADD 7
        vecs[5] = '{16'h2803, 7'b10_1_1_0_0_0, 1'b0, 1'b0};  // ADDI 3
        vecs[6] = '{16'h3004, 7'b10_0_1_1_0_1, 1'b0, 1'b0};  // SUB 4
        vecs[7] = '{16'h3FFF, 7'b10_1_1_1_0_0, 1'b0, 1'b0};  // SUBI 0x7FF
        vecs[8] = '{16'h4000, 7'b00_0_0_0_0_0, 1'b1, 1'b0};  // first undefined
        vecs[9] = '{16'hF800, 7'b00_0_0_0_0_0, 1'b1, 1'b0};  // last undefined

        clear_mem(16'h0000);
        mem0[0] = 16'h1805;

        // Reset state while reset is held low
        #1 reset = 1'b0;
        tick(2);
        check("rst_addr",    32'(bus0.Instr_Addr),  32'h0);
        check("rst_operand", 32'(bus0.Operand),     32'h0);
        check("rst_strobes", 32'(strobes),          32'h0);
        check("rst_halted",  32'(bus0.Halted),      32'h0);
        check("rst_illegal", 32'(bus0.Illegal),     32'h0);
        check("rst_count",   32'(bus0.Cycle_Count), 32'h0);
        reset = 1'b1;

        // Single-instruction vectors, each followed by HLT
        for (int i = 0; i < 10; i++) begin
            clear_mem(16'h0000);
            mem0[0] = vecs[i].instr;
            do_reset();
            check($sformatf("v%0d_fetch_strobes", i), 32'(strobes), 32'h0);
            tick(1);
            check($sformatf("v%0d_decode_strobes", i), 32'(strobes), 32'h0);
            tick(1);
            check($sformatf("v%0d_exec_strobes", i), 32'(strobes), 32'(vecs[i].exp_ctrl));
            check($sformatf("v%0d_exec_operand", i), 32'(bus0.Operand), 32'(vecs[i].instr[10:0]));
            check($sformatf("v%0d_exec_illegal", i), 32'(bus0.Illegal), 32'h0);
            tick(1);
            check($sformatf("v%0d_post_strobes", i), 32'(strobes), 32'h0);
            check($sformatf("v%0d_post_illegal", i), 32'(bus0.Illegal), 32'(vecs[i].exp_illegal));
            check($sformatf("v%0d_post_halted", i), 32'(bus0.Halted), 32'(vecs[i].exp_halt));
            check($sformatf("v%0d_post_addr", i), 32'(bus0.Instr_Addr), vecs[i].exp_halt ? 32'h0 : 32'h1);
            tick(4);
            check($sformatf("v%0d_end_halted", i), 32'(bus0.Halted), 32'h1);
            check($sformatf("v%0d_end_addr", i), 32'(bus0.Instr_Addr), vecs[i].exp_halt ? 32'h0 : 32'h1);
            check($sformatf("v%0d_end_illegal", i), 32'(bus0.Illegal), 32'(vecs[i].exp_illegal));
            check($sformatf("v%0d_end_strobes", i), 32'(strobes), 32'h0);
        end

        // LDI 5 / ADDI 3 / STO 0x010 / HLT
        clear_mem(16'h0000);
        mem0[0] = 16'h1805;
        mem0[1] = 16'h2803;
        mem0[2] = 16'h0810;
        mem0[3] = 16'h0000;
        do_reset();
        tick(2);
        check("prog_ldi_strobes",  32'(strobes),      32'(7'b01_0_1_0_0_0));
        check("prog_ldi_operand",  32'(bus0.Operand), 32'h5);
        tick(3);
        check("prog_addi_strobes", 32'(strobes),      32'(7'b10_1_1_0_0_0));
        check("prog_addi_operand", 32'(bus0.Operand), 32'h3);
        tick(3);
        check("prog_sto_strobes",  32'(strobes),      32'(7'b00_0_0_0_1_0));
        check("prog_sto_operand",  32'(bus0.Operand), 32'h10);
        tick(3);
        check("prog_hlt_strobes",  32'(strobes),      32'h0);
        check("prog_hlt_halted",   32'(bus0.Halted),  32'h0);
        tick(1);
        check("prog_halted",       32'(bus0.Halted),      32'h1);
        check("prog_pc",           32'(bus0.Instr_Addr),  32'h3);
        check("prog_count",        32'(bus0.Cycle_Count), 32'd12);
        check("sat_count_12",      32'(bus1.Cycle_Count), 32'd12);
        tick(6);
        check("prog_frozen_pc",    32'(bus0.Instr_Addr),  32'h3);
        check("prog_frozen_count", 32'(bus0.Cycle_Count), 32'd12);
        check("prog_frozen_halt",  32'(bus0.Halted),      32'h1);
        check("sat_count_15",      32'(bus1.Cycle_Count), 32'd15);
        tick(5);
        check("sat_count_held",    32'(bus1.Cycle_Count), 32'd15);

        // PC wrap through NOP-filled memory
        clear_mem(16'h4000);
        do_reset();
        tick(2047 * 3);
        check("wrap_addr_2047",  32'(bus0.Instr_Addr),  32'd2047);
        tick(3);
        check("wrap_addr_0",     32'(bus0.Instr_Addr),  32'd0);
        check("wrap_count",      32'(bus0.Cycle_Count), 32'd6144);
        check("wrap_illegal",    32'(bus0.Illegal),     32'h1);
        check("wrap_halted",     32'(bus0.Halted),      32'h0);
        check("wrap_sat_count",  32'(bus1.Cycle_Count), 32'd15);

        // Reset asserted during the EXECUTE of STO
        clear_mem(16'h0000);
        mem0[0] = 16'h1805;
        mem0[1] = 16'h0810;
        do_reset();
        tick(5);
        check("abort_sto_wrram", 32'(bus0.WrRam),      32'h1);
        check("abort_sto_addr",  32'(bus0.Instr_Addr), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("abort_strobes",   32'(strobes),          32'h0);
        check("abort_addr",      32'(bus0.Instr_Addr),  32'h0);
        check("abort_operand",   32'(bus0.Operand),     32'h0);
        check("abort_count",     32'(bus0.Cycle_Count), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_refetch_addr", 32'(bus0.Instr_Addr), 32'h0);
        @(negedge clk);
        check("abort_decode_strobes", 32'(strobes), 32'h0);
        tick(1);
        check("abort_restart_ldi", 32'(strobes), 32'(7'b01_0_1_0_0_0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 11, meaning program-counter and instruction-address width.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, meaning cycle-counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port Instr_Addr, output, PC_WIDTH bits: program memory address, equal to PC.
REQ-006 The block SHALL have port Instr_Data, input, 16 bits: program memory read data, valid one cycle after Instr_Addr.
REQ-007 The block SHALL have port Operand, output, 11 bits: IR[10:0], driven to the datapath and data memory address.
REQ-008 The block SHALL have port SelA, output, 2 bits: accumulator source select (00 memory, 01 immediate, 10 ALU).
REQ-009 The block SHALL have port SelB, output, 1 bit: ALU B select (0 memory, 1 immediate).
REQ-010 The block SHALL have port WrAcc, output, 1 bit: accumulator write enable.
REQ-011 The block SHALL have port Op, output, 1 bit: ALU operation (0 add, 1 subtract).
REQ-012 The block SHALL have port WrRam and port RdRam, outputs, 1 bit each: data memory write and read strobes.
REQ-013 The block SHALL have port Halted, output, 1 bit: high while in HALT.
REQ-014 The block SHALL have port Illegal, output, 1 bit: sticky flag for an undefined opcode.
REQ-015 The block SHALL have port Cycle_Count, output, CNT_WIDTH bits: clocks elapsed since reset while not halted.

Function
REQ-016 The FSM SHALL have states FETCH, DECODE, EXECUTE and HALT, with transitions FETCH->DECODE->EXECUTE->FETCH, and EXECUTE->HALT on HLT; one instruction takes 3 cycles.
REQ-017 FETCH: Instr_Addr=PC; no strobes asserted.
REQ-018 DECODE: IR<=Instr_Data on the exiting edge.
REQ-019 EXECUTE: strobes SHALL be decoded from IR[15:11] and SHALL be asserted for exactly this one cycle; PC<=PC+1 on the exiting edge, except on HLT.
REQ-020 Decode (unlisted strobes 0, SelA/SelB/Op 0 when unlisted): 00000 HLT none; 00001 STO WrRam; 00010 LD RdRam,SelA=00,WrAcc; 00011 LDI SelA=01,WrAcc; 00100 ADD RdRam,SelA=10,SelB=0,Op=0,WrAcc; 00101 ADDI SelA=10,SelB=1,Op=0,WrAcc; 00110 SUB RdRam,SelA=10,SelB=0,Op=1,WrAcc; 00111 SUBI SelA=10,SelB=1,Op=1,WrAcc.
REQ-021 Opcodes 01000-11111 SHALL execute as NOP (no strobes), SHALL increment PC, and SHALL set Illegal, which stays 1 until reset.
REQ-022 Outside EXECUTE, WrAcc, WrRam and RdRam SHALL be 0, and SelA, SelB and Op SHALL be 0.
REQ-023 Operand SHALL equal IR[10:0] in every state.
REQ-024 PC SHALL wrap from 2^PC_WIDTH-1 to 0.
REQ-025 HALT: all strobes 0, PC, IR and Cycle_Count frozen, and Halted=1 from the first HALT cycle until reset.
REQ-026 Cycle_Count SHALL increment on every rising edge while not in HALT (including the edge entering HALT), and SHALL saturate at all-ones.
REQ-027 Strobes SHALL be registered or decoded from registered state only, and SHALL have no combinational path from Instr_Data.

Reset
REQ-028 When reset=0, asynchronously: state=FETCH, PC=0, IR=0, Cycle_Count=0, Halted=0, Illegal=0, all strobes/selects=0, Instr_Addr=0, Operand=0.
REQ-029 Reset asserted mid-instruction SHALL abort the instruction with no further strobes; after reset=1, the first FETCH SHALL present address 0 on the next cycle.

Verification
REQ-030 Scenario: program LDI 5 (0x1805), ADDI 3 (0x2803), STO 0x010 (0x0810), HLT at 0-3 -> EXECUTE cycles show WrAcc/SelA=01/Operand=5; WrAcc/SelA=10/SelB=1/Op=0/Operand=3; WrRam/Operand=0x010; then Halted=1 with PC=3 and Cycle_Count=12 frozen.
REQ-031 Scenario: SUB 0x004 (0x3004) -> exactly one cycle of RdRam=1, SelA=10, SelB=0, Op=1, WrAcc=1, Operand=4.
REQ-032 Scenario: opcode 0xF800 at address 0 followed by HLT -> no strobes, Illegal=1 after the EXECUTE edge, PC=1, and Illegal still 1 in HALT.
REQ-033 Scenario: PC preset to 2047 by executing NOP-filled memory -> the fetch after address 2047 presents Instr_Addr=0.
REQ-034 Scenario: reset pulled low during the EXECUTE of STO -> WrRam drops immediately, all outputs return to reset values, and the next fetch presents address 0.
REQ-035 Scenario: CNT_WIDTH=4 with a long NOP program -> Cycle_Count saturates at 15 and does not wrap.
